game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 168 ++++++++++++++++
 tb/tb_game_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game flow controller: cover screen, 3-2-1 countdown, play/pause, game-over timeout.
// Also tracks A/D key holds for steering and registers the floor speed level.
module game_sequencer #(
  parameter int COUNT_TICKS = 60,
  parameter int OVER_TICKS  = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_is_down,
  input  logic       slime_die,
  input  logic [3:0] score_tens,
  output logic [2:0] state,
  output logic       game_rst,
  output logic       play_en,
  output logic [1:0] move_dir,
  output logic [1:0] count_digit,
  output logic [2:0] speed_level,
  output logic       record_strobe
);

  typedef enum logic [2:0] {
    S_COVER     = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  localparam logic [8:0] K_ENTER   = 9'h05A;
  localparam logic [8:0] K_ENTER_X = 9'h15A;
  localparam logic [8:0] K_A       = 9'h01C;
  localparam logic [8:0] K_D       = 9'h023;
  localparam logic [8:0] K_P       = 9'h04D;
  localparam logic [8:0] K_ESC     = 9'h076;

  localparam int MAXT = (COUNT_TICKS > OVER_TICKS) ? COUNT_TICKS : OVER_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(COUNT_TICKS - 1);
  localparam logic [CW-1:0] OVER_LAST = CW'(OVER_TICKS - 1);

  state_t        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          grst_d, rec_d;
  logic          a_held, d_held, d_last;
  logic [2:0]    speed_q;

  logic make, enter_mk, p_mk, esc_mk, a_ev, d_ev;

  assign make     = key_valid & key_is_down;
  assign enter_mk = make & ((key_code == K_ENTER) | (key_code == K_ENTER_X));
  assign p_mk     = make & (key_code == K_P);
  assign esc_mk   = make & (key_code == K_ESC);
  assign a_ev     = key_valid & (key_code == K_A);
  assign d_ev     = key_valid & (key_code == K_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= S_COVER;
      cnt_q         <= '0;
      dig_q         <= '0;
      game_rst      <= 1'b0;
      record_strobe <= 1'b0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      game_rst      <= grst_d;
      record_strobe <= rec_d;
    end
  end

  // Key events are evaluated before ticks, so a transition caused by a key
  // swallows a coincident tick via the counter clear on state entry.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    grst_d = 1'b0;
    rec_d  = 1'b0;
    unique case (st_q)
      S_COVER: begin
        if (enter_mk) begin
          st_d   = S_COUNTDOWN;
          dig_d  = 2'd3;
          grst_d = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (dig_q == 2'd1) st_d = S_PLAY;
            else               dig_d = dig_q - 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (slime_die) begin
          st_d  = S_OVER;
          rec_d = 1'b1;
        end else if (p_mk) begin
          st_d = S_PAUSE;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (esc_mk) begin
          st_d   = S_COVER;
          grst_d = 1'b1;
        end else if (p_mk) begin
          st_d = S_PLAY;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OVER: begin
        if (tick) begin
          if (cnt_q == OVER_LAST) st_d = S_COVER;
          else                    cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = S_COVER;
    endcase
    if (st_d != st_q) cnt_d = '0;
  end

  // d_last remembers which of A/D was pressed most recently
  always_ff @(posedge clk) begin
    if (rst) begin
      a_held <= 1'b0;
      d_held <= 1'b0;
      d_last <= 1'b0;
    end else begin
      if (a_ev) a_held <= key_is_down;
      if (d_ev) d_held <= key_is_down;
      if (a_ev & key_is_down)      d_last <= 1'b0;
      else if (d_ev & key_is_down) d_last <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 speed_q <= '0;
    else if (game_rst)       speed_q <= '0;
    else if (st_q == S_PLAY) speed_q <= (score_tens > 4'd7) ? 3'd7 : score_tens[2:0];
  end

  always_comb begin
    move_dir = 2'b00;
    if (st_q == S_PLAY) begin
      if (a_held && d_held) move_dir = d_last ? 2'b01 : 2'b10;
      else if (a_held)      move_dir = 2'b10;
      else if (d_held)      move_dir = 2'b01;
    end
  end

  assign state       = st_q;
  assign play_en     = (st_q == S_PLAY);
  assign count_digit = (st_q == S_COUNTDOWN) ? dig_q : 2'd0;
  assign speed_level = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomized check of game_sequencer against a tick-count based
// reference model of the game flow.
module tb_game_sequencer;
  localparam int CT = 2;
  localparam int OT = 3;
  localparam logic [8:0] ENT = 9'h05A, ENTX = 9'h15A, KA = 9'h01C, KD = 9'h023,
                         KP = 9'h04D, KESC = 9'h076;

  logic       clk = 1'b0;
  logic       rst, tick, key_valid, key_is_down, slime_die;
  logic [8:0] key_code;
  logic [3:0] score_tens;
  logic [2:0] state, speed_level;
  logic       game_rst, play_en, record_strobe;
  logic [1:0] move_dir, count_digit;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: state id, ticks seen since entering it, pending pulses
  int m_st = 0, m_ticks = 0, m_speed = 0, m_stamp = 0, m_at = 0, m_dt = 0;
  bit m_grst = 0, m_rec = 0, m_a = 0, m_d = 0;

  game_sequencer #(.COUNT_TICKS(CT), .OVER_TICKS(OT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_code(key_code),
    .key_is_down(key_is_down), .slime_die(slime_die), .score_tens(score_tens),
    .state(state), .game_rst(game_rst), .play_en(play_en), .move_dir(move_dir),
    .count_digit(count_digit), .speed_level(speed_level), .record_strobe(record_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit mk;
    int nst;
    if (rst) begin
      m_st = 0; m_ticks = 0; m_speed = 0; m_grst = 0; m_rec = 0; m_a = 0; m_d = 0;
      return;
    end
    if (m_grst) m_speed = 0;
    else if (m_st == 2) m_speed = (score_tens > 7) ? 7 : int'(score_tens);
    m_grst = 0; m_rec = 0;
    if (key_valid && key_code == KA) begin
      m_a = key_is_down;
      if (key_is_down) m_at = ++m_stamp;
    end
    if (key_valid && key_code == KD) begin
      m_d = key_is_down;
      if (key_is_down) m_dt = ++m_stamp;
    end
    mk = key_valid && key_is_down;
    nst = m_st;
    case (m_st)
      0: if (mk && (key_code == ENT || key_code == ENTX)) begin nst = 1; m_grst = 1; end
      1: if (tick) begin m_ticks++; if (m_ticks == 3 * CT) nst = 2; end
      2: if (slime_die) begin nst = 4; m_rec = 1; end
         else if (mk && key_code == KP) nst = 3;
      3: if (mk && key_code == KESC) begin nst = 0; m_grst = 1; end
         else if (mk && key_code == KP) nst = 2;
      default: if (tick) begin m_ticks++; if (m_ticks == OT) nst = 0; end
    endcase
    if (nst != m_st) m_ticks = 0;
    m_st = nst;
  endtask

  task automatic check_all();
    int dir;
    dir = 0;
    if (m_st == 2) begin
      if (m_a && m_d) dir = (m_at > m_dt) ? 2 : 1;
      else if (m_a)   dir = 2;
      else if (m_d)   dir = 1;
    end
    chk("state", 8'(state), 8'(m_st));
    chk("game_rst", 8'(game_rst), 8'(m_grst));
    chk("record_strobe", 8'(record_strobe), 8'(m_rec));
    chk("play_en", 8'(play_en), 8'(m_st == 2));
    chk("move_dir", 8'(move_dir), 8'(dir));
    chk("count_digit", 8'(count_digit), (m_st == 1) ? 8'(3 - m_ticks / CT) : 8'd0);
    chk("speed_level", 8'(speed_level), 8'(m_speed));
  endtask

  task automatic cyc(input bit r, input bit t, input bit kv, input logic [8:0] kc,
                     input bit dn, input bit die);
    rst = r; tick = t; key_valid = kv; key_code = kc; key_is_down = dn; slime_die = die;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    rst = 0; tick = 0; key_valid = 0; key_is_down = 0; slime_die = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 9'h0, 0, 0);
  endtask

  task automatic key(input logic [8:0] kc, input bit dn);
    cyc(0, 0, 1, kc, dn, 0);
  endtask

  // ENTER from COVER, then six ticks spread over idle cycles
  task automatic start_game();
    key(ENT, 1);
    for (int i = 0; i < 3 * CT; i++) begin
      idle(1);
      cyc(0, 1, 0, 9'h0, 0, 0);
    end
  endtask

  initial begin
    logic [8:0] codes [8];
    codes = '{ENT, ENTX, KA, KD, KP, KESC, 9'h11C, 9'h0F0};
    score_tens = 4'd2;
    cyc(1, 0, 0, 9'h0, 0, 0);
    cyc(1, 1, 1, ENT, 1, 1);
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_dir", 8'(move_dir), 8'd0);

    // break of ENTER and extended-A do nothing in COVER
    key(ENT, 0);
    key(9'h11C, 1);
    chk("cover_hold", 8'(state), 8'd0);

    // ENTER with coincident tick: tick is not counted in COUNTDOWN
    cyc(0, 1, 1, ENT, 1, 0);
    chk("cd_entry", 8'(state), 8'd1);
    chk("cd_grst", 8'(game_rst), 8'd1);
    chk("cd_digit3", 8'(count_digit), 8'd3);
    idle(2);
    chk("cd_grst_off", 8'(game_rst), 8'd0);
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 0, 9'h0, 0, 0); idle(1); end
    chk("cd_digit1", 8'(count_digit), 8'd1);
    cyc(0, 1, 0, 9'h0, 0, 0);
    chk("play_after6", 8'(state), 8'd2);
    chk("play_en", 8'(play_en), 8'd1);

    // steering: most recent press wins, release falls back to the other key
    key(KA, 1);  chk("dir_a", 8'(move_dir), 8'd2);
    key(KD, 1);  chk("dir_ad", 8'(move_dir), 8'd1);
    key(KD, 0);  chk("dir_a_again", 8'(move_dir), 8'd2);
    key(KD, 1);
    key(KA, 0);  chk("dir_d", 8'(move_dir), 8'd1);
    key(KD, 0);

    score_tens = 4'd9;
    idle(2);
    chk("speed_sat", 8'(speed_level), 8'd7);
    score_tens = 4'd5;
    idle(1);

    // pause/resume, then ESC to cover with A held
    key(KP, 1);  chk("pause", 8'(state), 8'd3);
    cyc(0, 1, 0, 9'h0, 0, 1);
    chk("pause_die_ignored", 8'(state), 8'd3);
    key(KP, 1);  chk("resume", 8'(state), 8'd2);
    key(KP, 1);
    key(KA, 1);
    key(KESC, 1);
    chk("esc_cover", 8'(state), 8'd0);
    chk("esc_grst", 8'(game_rst), 8'd1);
    chk("esc_dir", 8'(move_dir), 8'd0);
    key(KA, 0);
    idle(1);
    chk("speed_clr", 8'(speed_level), 8'd0);

    // die beats P in the same cycle; OVER ignores ENTER and lasts OT ticks
    start_game();
    cyc(0, 0, 1, KP, 1, 1);
    chk("over", 8'(state), 8'd4);
    chk("over_rec", 8'(record_strobe), 8'd1);
    chk("over_play_en", 8'(play_en), 8'd0);
    idle(1);
    chk("rec_off", 8'(record_strobe), 8'd0);
    cyc(0, 1, 0, 9'h0, 0, 0);
    cyc(0, 1, 1, ENT, 1, 0);
    chk("over_keys_ignored", 8'(state), 8'd4);
    cyc(0, 1, 0, 9'h0, 0, 0);
    chk("over_done", 8'(state), 8'd0);

    // reset mid-play
    start_game();
    score_tens = 4'd6;
    idle(2);
    cyc(1, 0, 0, 9'h0, 0, 1);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_speed", 8'(speed_level), 8'd0);
    chk("rst_rec", 8'(record_strobe), 8'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, t, kv, dn, die;
      if ($urandom_range(0, 19) == 0) score_tens = 4'($urandom_range(0, 9));
      r   = ($urandom_range(0, 499) == 0);
      t   = ($urandom_range(0, 2) == 0);
      kv  = ($urandom_range(0, 3) == 0);
      dn  = $urandom_range(0, 1) == 1;
      die = ($urandom_range(0, 39) == 0);
      cyc(r, t, kv, codes[$urandom_range(0, 7)], dn, die);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
